flop_bank_arb: RTL and testbench

Shared register bank of DEPTH x WIDTH flop storage, with a round-robin write arbiter serving NREQ requesters over valid/ready. It also provides a registered read port and a clear sequencer that zeroes the bank one entry per cycle. It sits in the GPU common module library and is the single owner and scheduler of the bank storage; requesters never write the flops directly.

---
 rtl/flop_bank_arb_pkg.sv | 21 ++
 rtl/flop_bank_arb_rr_arbiter.sv | 52 +++++
 rtl/flop_bank_arb.sv | 135 +++++++++++++
 tb/tb_flop_bank_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flop_bank_arb_pkg.sv
// Shared definitions for the flop bank arbiter: FSM encoding, widths and
// an elaboration-time log2 helper.
package flop_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Width of grant_id; enough for up to 8 requesters.
  localparam int GRANT_IDW = 3;

  // Ceiling log2, used to check that AW matches DEPTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/flop_bank_arb_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant, with the
// search starting at a registered pointer that moves past each winner.
module rr_arbiter
  import flop_bank_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      valid,
  output logic [NREQ-1:0]      grant,
  output logic [GRANT_IDW-1:0] grant_idx,
  output logic                 grant_any
);

  logic [GRANT_IDW-1:0] ptr_q, ptr_d;

  // True when requester j (0..NREQ-1) is requesting; loop keeps indices constant.
  function automatic logic valid_at(input logic [NREQ-1:0] v, input int j);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NREQ; i++) if (i == j) r = v[i];
    return r;
  endfunction

  // Scan from ptr downward-in-priority so the nearest requester above ptr wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (en && valid_at(valid, (int'(ptr_q) + k) % NREQ)) begin
        grant_any = 1'b1;
        grant_idx = GRANT_IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = grant_any && (grant_idx == GRANT_IDW'(i));
    end
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == GRANT_IDW'(NREQ - 1)) ? '0 : grant_idx + GRANT_IDW'(1);
    end
  end

  // Pointer register; only a completed handshake moves it.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/flop_bank_arb.sv
// Shared DEPTH x WIDTH flop bank with a round-robin write arbiter, a
// registered read port and a one-entry-per-cycle clear sequencer.
//
// Handshake: a write transfers at the posedge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational and one-hot;
// requesters hold valid/addr/data until ready, and may drop valid early
// (no write then). No grant is given in CLEAR, on a clr_start cycle or
// during reset, so the clear sweep and the bank owner never collide.
module flop_bank_arb
  import flop_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic [GRANT_IDW-1:0]   grant_id,
  output state_e                 dbg_state
);

  if (AW != clog2(DEPTH)) begin : g_bad_aw
    $error("flop_bank_arb: AW must equal log2(DEPTH)");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("flop_bank_arb: NREQ must be 2..8");
  end

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  clr_busy_q, clr_busy_d;
  logic [GRANT_IDW-1:0]  grant_id_q, grant_id_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  arb_en;
  logic                  grant_any;
  logic [GRANT_IDW-1:0]  grant_idx;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;

  // Arbitrate only when the bank is idle and no sweep is being started.
  assign arb_en = !rst && (state_q == IDLE) && !clr_start;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Select the winner's address and data for the bank write.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        wr_addr = req_addr[i*AW +: AW];
        wr_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the clear FSM, grant id and read port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    clr_busy_d = (state_d == CLEAR);
    grant_id_d = grant_any ? grant_idx : grant_id_q;
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? mem[rd_addr] : rd_data_q;
  end

  // FSM state, sweep counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      grant_id_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      grant_id_q <= grant_id_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Bank storage, not reset; reset also blocks the pending sweep write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)  mem[cnt_q]   <= '0;
      else if (grant_any)    mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign clr_busy  = clr_busy_q;
  assign grant_id  = grant_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flop_bank_arb.sv
// Self-checking bench for flop_bank_arb: directed scenarios plus a random
// phase, all compared each cycle against a behavioural bank model.
module tb_flop_bank_arb;
  import flop_bank_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  clr_start;
  logic                  clr_busy;
  logic [2:0]            grant_id;
  state_e                dbg_state;

  always #5 clk = ~clk;

  flop_bank_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int               n_vec  = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_known [DEPTH];
  int               m_ptr, m_gid, m_cidx, last_w;
  bit               m_clear, m_rdv, m_rdd_known;
  logic [WIDTH-1:0] m_rdd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requesting index scanning upward from ptr, wrapping; -1 if none.
  function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_gid = 0; m_clear = 0; m_cidx = 0;
    m_rdv = 0; m_rdd = '0; m_rdd_known = 1;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid[i]           = v;
    req_addr[i*AW +: AW]   = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Called at a negedge with inputs already driven: check, clock, update model.
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    #1;
    w  = (rst || m_clear || clr_start) ? -1 : winner(req_valid, m_ptr);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("clr_busy",  clr_busy, m_clear);
    chk("state",     dbg_state, m_clear);
    chk("grant_id",  grant_id, m_gid);
    chk("rd_valid",  rd_valid, m_rdv);
    if (m_rdv && m_rdd_known) begin
      if (exp_q.size() == 0) chk("rd_queue_empty", 1, 0);
      else m_rdd = exp_q.pop_front();
      chk("rd_data", rd_data, m_rdd);
    end else if (!m_rdv && m_rdd_known) begin
      chk("rd_hold", rd_data, m_rdd);
    end
    last_w = w;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rd_en) begin
        m_rdv = 1;
        m_rdd_known = m_known[rd_addr];
        if (m_known[rd_addr]) exp_q.push_back(m_mem[rd_addr]);
      end else begin
        m_rdv = 0;
      end
      if (m_clear) begin
        m_mem[m_cidx] = '0; m_known[m_cidx] = 1;
        m_cidx++;
        if (m_cidx == DEPTH) m_clear = 0;
      end else if (clr_start) begin
        m_clear = 1; m_cidx = 0;
      end else if (w >= 0) begin
        m_mem[req_addr[w*AW +: AW]]   = req_data[w*WIDTH +: WIDTH];
        m_known[req_addr[w*AW +: AW]] = 1;
        m_ptr = (w + 1) % NREQ;
        m_gid = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; rd_en = 0; clr_start = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step(); rst = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] t5_data [DEPTH];
  int zeros, busy;
  bit granted;
  logic [WIDTH-1:0] v32;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    req_addr = '0; req_data = '0; rd_addr = '0; last_w = -1;
    idle_inputs(); rst = 1;
    @(posedge clk); @(negedge clk);
    model_reset();
    do_reset();

    // T1: single requester 2 writes, then read back.
    set_req(2, 1, 5, 32'hDEADBEEF);
    #1 chk("t1_ready", req_ready, 4'b0100);
    step();
    set_req(2, 0, 5, 32'hDEADBEEF);
    rd_en = 1; rd_addr = 5;
    step();
    rd_en = 0;
    #1 chk("t1_rd_data", rd_data, 32'hDEADBEEF);
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_grant_id", grant_id, 2);

    // T2: all requesters valid from reset -> 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, AW'(8 + i), WIDTH'(32'hA0 + i));
    for (int c = 0; c < 5; c++) begin
      v32 = 32'(1) << (c % NREQ);
      #1 chk("t2_order", req_ready, v32[NREQ-1:0]);
      step();
      chk("t2_grant_id", grant_id, c % NREQ);
    end
    idle_inputs();

    // T3: read-before-write on the same address.
    set_req(0, 1, 7, 32'h22); step();
    set_req(0, 1, 7, 32'h11); rd_en = 1; rd_addr = 7; step();
    set_req(0, 0, 7, 32'h11);
    #1 chk("t3_old", rd_data, 32'h22);
    step();
    rd_en = 0;
    #1 chk("t3_new", rd_data, 32'h11);

    // T4: fill, clear with requester 0 waiting, verify all zero.
    for (int a = 0; a < DEPTH; a++) begin
      set_req(a % NREQ, 1, AW'(a), $urandom()); step(); req_valid = '0;
    end
    clr_start = 1; set_req(0, 1, 3, 32'h5A5A);
    zeros = 0; busy = 0; granted = 0;
    for (int c = 0; c < 30 && !granted; c++) begin
      #1;
      if (req_ready[0]) granted = 1;
      else begin zeros++; if (clr_busy) busy++; end
      step();
      clr_start = 0;
    end
    req_valid = '0;
    chk("t4_ready_low", zeros, 17);
    chk("t4_busy_cycles", busy, 16);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = AW'(a); step();
      #1 chk("t4_rd", rd_data, (a == 3) ? 32'h5A5A : 32'h0);
    end
    rd_en = 0;

    // T5: reset aborts the sweep after 5 entries.
    for (int a = 0; a < DEPTH; a++) begin
      t5_data[a] = $urandom();
      set_req((a + 2) % NREQ, 1, AW'(a), t5_data[a]); step(); req_valid = '0;
    end
    clr_start = 1; step(); clr_start = 0;
    for (int c = 0; c < 5; c++) step();
    rst = 1; step(); rst = 0;
    #1 chk("t5_busy", clr_busy, 0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = AW'(a); step();
      #1 chk("t5_rd", rd_data, (a < 5) ? 32'h0 : t5_data[a]);
    end
    rd_en = 0;
    req_valid = '1;
    #1 chk("t5_ptr0", req_ready, 4'b0001);
    step();
    idle_inputs();

    // T6: requester 1 drops valid before grant; its entry is untouched.
    set_req(3, 1, 12, 32'h33); step(); req_valid = '0;
    set_req(0, 1, 9, 32'h99); set_req(1, 1, 10, 32'hBAD);
    #1 chk("t6_ready", req_ready, 4'b0001);
    step();
    set_req(1, 0, 10, 32'hBAD);
    step(); step();
    req_valid = '0; rd_en = 1; rd_addr = 10; step(); rd_en = 0;
    #1 chk("t6_untouched", rd_data, t5_data[10]);

    // Random phase honouring the hold-until-ready rule.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && last_w != i) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 0;
        end else begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom());
        end
      end
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = AW'($urandom_range(0, DEPTH - 1));
      clr_start = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
